key_scan_debounce: RTL and testbench
====================================

// Module: key_scan_debounce
// PURPOSE
//  Front-end conditioning for the five active-low panel keys (ke, ku, kd, kl, kr).
//  Synchronises, debounces and edge-detects each key, and produces clean one-cycle press/release/repeat pulses.
//  Sits directly upstream of the countdown-timer control FSM, which consumes pulses instead of running per-key counters.
//  Auto-repeat on held ku/kd lets the digit under edit step continuously.
// PARAMETERS
//  NKEYS        5           number of key channels; bit order 0=ke 1=ku 2=kd 3=kl 4=kr
//  DEBOUNCE_CYC 1_000_000   stable-level cycles required to accept a press or release (20 ms @ 50 MHz)
//  REPEAT_DLY   25_000_000  cycles from press pulse to first repeat pulse (500 ms)
//  REPEAT_RATE  5_000_000   cycles between subsequent repeat pulses (100 ms)
//  REPEAT_MASK  5'b00110    per-key auto-repeat enable (default ku, kd)
// PORTS
//  clkin        in   1      system clock, 50 MHz
//  rst_n        in   1      synchronous active-low reset
//  key_n        in   NKEYS  raw asynchronous keys, 0 = pressed
//  key_level    out  NKEYS  debounced level, 1 = pressed
//  key_press    out  NKEYS  1-cycle pulse on accepted press
//  key_release  out  NKEYS  1-cycle pulse on accepted release
//  key_repeat   out  NKEYS  1-cycle pulse per auto-repeat tick; masked keys only
//  any_pressed  out  1      OR of key_level
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clkin): sync flops=1 (released), all channels IDLE, counters 0; all outputs 0.
//    Reset mid-press discards the press: no release pulse follows.
//  - Sync: 2-flop synchroniser per key. FSM sees s = sync2 (0 = pressed). All outputs are registered.
//  - Per-channel FSM, cnt width $clog2(max param)+1, saturating never needed:
//    IDLE:     s==0 -> PRESS_WAIT, cnt<=0.
//    PRESS_WAIT: s==1 -> IDLE (bounce, no pulse); else cnt++.
//              At cnt==DEBOUNCE_CYC-1 -> HELD, key_press=1 for 1 cycle, key_level<=1, rpt<=0.
//    HELD:     s==1 -> RELEASE_WAIT, cnt<=0; else rpt++ (masked keys only).
//    RELEASE_WAIT: s==0 -> HELD (bounce, no pulse, rpt keeps value); else cnt++.
//              At cnt==DEBOUNCE_CYC-1 -> IDLE, key_release=1 for 1 cycle, key_level<=0.
//  - Latency: key_n stable low from edge k -> key_press high in cycle k+2+DEBOUNCE_CYC. Release is symmetric.
//  - Repeat (HELD, REPEAT_MASK[i]=1):
//    first key_repeat when rpt==REPEAT_DLY-1; then rpt<=REPEAT_DLY-REPEAT_RATE, so pulses recur every REPEAT_RATE cycles.
//    No repeat pulse in any other state; unmasked keys never assert key_repeat.
//  - Channels are fully independent. Simultaneous presses give coincident pulses on each bit; there is no priority or lockout.
//  - key_press and key_release never coincide on one bit.
//    key_repeat never coincides with key_press on one bit (REPEAT_DLY>=1 required).
//  - Parameter legality: DEBOUNCE_CYC>=2, REPEAT_RATE>=1, REPEAT_RATE<=REPEAT_DLY.
// STRUCTURE
//  - Shared package key_pkg:
//    key index constants KEY_E=0, KEY_U=1, KEY_D=2, KEY_L=3, KEY_R=4;
//    channel state encoding ST_IDLE/ST_PWAIT/ST_HELD/ST_RWAIT (2 bits).
//  - Sub-module key_debounce_ch: one channel (synchroniser, FSM, cnt, rpt counters, 4 registered outputs),
//    with parameter RPT_EN.
//  - Top: generate loop of NKEYS instances, RPT_EN=REPEAT_MASK[i], plus registered any_pressed OR.
// TESTING (bench params: DEBOUNCE_CYC=8, REPEAT_DLY=20, REPEAT_RATE=6)
//  1. Reset: rst_n=0 for 3 cycles with key_n=5'b00000 -> all outputs 0. After release of rst_n, key_press pulses at cycle 2+8.
//  2. Clean press ku held 12 cycles, then released -> key_press[1] at +10, key_level[1]=1, key_release[1] 10 cycles after key_n rises.
//  3. Bounce: ke low 5 cycles, high 1, low 20 -> exactly one key_press[0], timed from the last falling edge. Release bounce gives no extra pulse.
//  4. Hold kd 60 cycles -> key_repeat[2] at press+20, +26, +32 ...; hold kl 60 cycles -> key_repeat[3] never asserts.
//  5. ke and kr pressed on the same cycle -> key_press[0] and key_press[4] coincide; any_pressed=1 until both are released.
//  6. rst_n=0 while ku is HELD -> key_level=0 next cycle, no key_release pulse.
//     With ku still low after reset, a fresh key_press[1] follows 2+8 cycles later.

Source files
------------

// File: rtl/key_scan_debounce_pkg.sv
// Shared definitions for the panel-key front end: key indices, channel
// state encoding and a small helper for sizing counters from parameters.
package key_pkg;

  localparam int KEY_E = 0;
  localparam int KEY_U = 1;
  localparam int KEY_D = 2;
  localparam int KEY_L = 3;
  localparam int KEY_R = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PWAIT = 2'd1,
    ST_HELD  = 2'd2,
    ST_RWAIT = 2'd3
  } key_st_e;

  // Largest of three timing parameters; the shared counter width derives from it.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_scan_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, auto-repeat counter
// and registered level/press/release/repeat outputs.
// Legal parameters: DEBOUNCE_CYC>=2, REPEAT_DLY>=1, 1<=REPEAT_RATE<=REPEAT_DLY.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned REPEAT_DLY   = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000,
  parameter bit          RPT_EN       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned CW = $clog2(max3(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_RATE)) + 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] RPT_LAST   = CW'(REPEAT_DLY - 1);
  // Reloading here makes every later tick land REPEAT_RATE cycles apart.
  localparam logic [CW-1:0] RPT_RELOAD = CW'(REPEAT_DLY - REPEAT_RATE);

  logic          sync1_q, sync2_q;
  key_st_e       st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rpt_q, rpt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  // State, counters, synchroniser and output registers; reset parks the key released.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      rpt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= key_ni;
      sync2_q   <= sync1_q;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      rpt_q     <= rpt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  // Debounce FSM on the synchronised level (0 = pressed); pulses default low.
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    rpt_d     = rpt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (!sync2_q) begin
          st_d  = ST_PWAIT;
          cnt_d = '0;
        end
      end
      ST_PWAIT: begin
        if (sync2_q) begin
          st_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          st_d    = ST_HELD;
          press_d = 1'b1;
          level_d = 1'b1;
          rpt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        if (sync2_q) begin
          st_d  = ST_RWAIT;
          cnt_d = '0;
        end else if (RPT_EN) begin
          if (rpt_q == RPT_LAST) begin
            repeat_d = 1'b1;
            rpt_d    = RPT_RELOAD;
          end else begin
            rpt_d = rpt_q + CW'(1);
          end
        end
      end
      ST_RWAIT: begin
        // A bounce back to pressed resumes HELD with the repeat phase intact.
        if (!sync2_q) begin
          st_d = ST_HELD;
        end else if (cnt_q == CNT_LAST) begin
          st_d      = ST_IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_scan_debounce.sv
// Panel-key front end: NKEYS independent debounce channels plus a registered
// any_pressed flag. any_pressed is the OR of the key_level registers, so it
// trails key_level by one cycle.
module key_scan_debounce
  import key_pkg::*;
#(
  parameter int unsigned          NKEYS        = 5,
  parameter int unsigned          DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned          REPEAT_DLY   = 25_000_000,
  parameter int unsigned          REPEAT_RATE  = 5_000_000,
  parameter logic [NKEYS-1:0]     REPEAT_MASK  = NKEYS'(5'b00110)
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_repeat,
  output logic             any_pressed
);

  logic any_q;

  for (genvar i = 0; i < NKEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_RATE (REPEAT_RATE),
      .RPT_EN      (REPEAT_MASK[i])
    ) u_ch (
      .clk_i    (clkin),
      .rst_ni   (rst_n),
      .key_ni   (key_n[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .repeat_o (key_repeat[i])
    );
  end

  // Registered OR of the debounced levels.
  always_ff @(posedge clkin) begin
    if (!rst_n) any_q <= 1'b0;
    else        any_q <= |key_level;
  end

  assign any_pressed = any_q;

endmodule

// File: tb/tb_key_scan_debounce.sv
// Bench for key_scan_debounce with short timing parameters: phase table,
// hand-timed corner sequences and random bouncy keys, all checked every cycle
// against a run-length reference model.
module tb_key_scan_debounce;
  import key_pkg::*;

  localparam int D    = 8;
  localparam int R    = 20;
  localparam int RATE = 6;
  localparam logic [4:0] MASK = 5'b00110;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] key_n = 5'b11111;
  logic [4:0] key_level, key_press, key_release, key_repeat;
  logic       any_pressed;

  key_scan_debounce #(
    .NKEYS(5), .DEBOUNCE_CYC(D), .REPEAT_DLY(R), .REPEAT_RATE(RATE), .REPEAT_MASK(MASK)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .key_n(key_n), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .key_repeat(key_repeat),
    .any_pressed(any_pressed)
  );

  always #5 clkin = ~clkin;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the FSM sees key_n two edges late; a press is accepted
  // after D+1 consecutive low samples while released, a release after D+1
  // consecutive high samples while pressed. Repeat ticks fall on the n-th
  // "pressed and still pressed" sample after the press where n>=R and
  // (n-R) is a multiple of RATE.
  logic [4:0] m_s1, m_s2, m_prev, m_level;
  int         m_low[5], m_high[5], m_hcnt[5];
  logic [4:0] e_level, e_press, e_rel, e_rep;
  logic       e_any;

  // Pulse accumulators for table phases.
  logic [4:0] acc_press, acc_rel;
  int         acc_rpt;

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [4:0] kn);
    logic s;
    e_press = '0; e_rel = '0; e_rep = '0;
    if (!r) begin
      m_s1 = '1; m_s2 = '1; m_prev = '1; m_level = '0; e_any = 1'b0;
      for (int i = 0; i < 5; i++) begin m_low[i] = 0; m_high[i] = 0; m_hcnt[i] = 0; end
    end else begin
      e_any = |m_level;
      for (int i = 0; i < 5; i++) begin
        s = m_s2[i];
        if (!s) begin m_low[i]++; m_high[i] = 0; end
        else    begin m_high[i]++; m_low[i] = 0; end
        if (m_level[i] && !s && !m_prev[i] && MASK[i]) begin
          m_hcnt[i]++;
          if (m_hcnt[i] >= R && ((m_hcnt[i] - R) % RATE) == 0) e_rep[i] = 1'b1;
        end
        if (!m_level[i] && m_low[i] == D + 1) begin
          e_press[i] = 1'b1; m_level[i] = 1'b1; m_hcnt[i] = 0;
        end else if (m_level[i] && m_high[i] == D + 1) begin
          e_rel[i] = 1'b1; m_level[i] = 1'b0;
        end
      end
      m_prev = m_s2; m_s2 = m_s1; m_s1 = kn;
    end
    e_level = m_level;
  endtask

  // One clock: drive on the falling edge, check just after the rising edge.
  task automatic cyc(input logic r, input logic [4:0] kn);
    @(negedge clkin);
    rst_n = r;
    key_n = kn;
    model_step(r, kn);
    @(posedge clkin);
    #1;
    chk("m_level",   key_level,   e_level);
    chk("m_press",   key_press,   e_press);
    chk("m_release", key_release, e_rel);
    chk("m_repeat",  key_repeat,  e_rep);
    chk("m_any",     {4'b0, any_pressed}, {4'b0, e_any});
    chk("press_rel_overlap", key_press & key_release, 5'b0);
    chk("press_rpt_overlap", key_press & key_repeat, 5'b0);
    acc_press |= key_press;
    acc_rel   |= key_release;
    acc_rpt   += $countones(key_repeat);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 5'b11111);
  endtask

  typedef struct {
    logic       rst;
    logic [4:0] kn;
    int         n;
    logic [4:0] lvl;
    logic [4:0] pmask;
    logic [4:0] rmask;
    int         rpt;
  } phase_t;

  phase_t tbl[11];

  initial begin
    logic [4:0] kn, kr;
    logic       r;

    tbl[0]  = '{1'b0, 5'b11111,  3, 5'b00000, 5'b00000, 5'b00000, 0};
    tbl[1]  = '{1'b1, 5'b11101, 12, 5'b00010, 5'b00010, 5'b00000, 0};
    tbl[2]  = '{1'b1, 5'b11111, 12, 5'b00000, 5'b00000, 5'b00010, 0};
    tbl[3]  = '{1'b1, 5'b11011, 40, 5'b00100, 5'b00100, 5'b00000, 2};
    tbl[4]  = '{1'b1, 5'b11111, 12, 5'b00000, 5'b00000, 5'b00100, 0};
    tbl[5]  = '{1'b1, 5'b10110, 15, 5'b01001, 5'b01001, 5'b00000, 0};
    tbl[6]  = '{1'b0, 5'b10110,  1, 5'b00000, 5'b00000, 5'b00000, 0};
    tbl[7]  = '{1'b1, 5'b11111, 12, 5'b00000, 5'b00000, 5'b00000, 0};
    tbl[8]  = '{1'b1, 5'b00000, 12, 5'b11111, 5'b11111, 5'b00000, 0};
    tbl[9]  = '{1'b0, 5'b00000,  2, 5'b00000, 5'b00000, 5'b00000, 0};
    tbl[10] = '{1'b1, 5'b11111, 12, 5'b00000, 5'b00000, 5'b00000, 0};

    acc_press = '0; acc_rel = '0; acc_rpt = 0;

    // Reset with every key held: all outputs stay low, then all press at +10.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 5'b00000);
      chk("t1_rst_level", key_level, 5'b0);
      chk("t1_rst_pulses", key_press | key_release | key_repeat, 5'b0);
      chk("t1_rst_any", {4'b0, any_pressed}, 5'b0);
    end
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, 5'b00000);
      chk("t1_press", key_press, (i == 10) ? 5'b11111 : 5'b00000);
    end
    chk("t1_level", key_level, 5'b11111);

    // Phase table.
    do_reset();
    foreach (tbl[p]) begin
      acc_press = '0; acc_rel = '0; acc_rpt = 0;
      for (int i = 0; i < tbl[p].n; i++) cyc(tbl[p].rst, tbl[p].kn);
      chk("tbl_level",   key_level, tbl[p].lvl);
      chk("tbl_press",   acc_press, tbl[p].pmask);
      chk("tbl_release", acc_rel,   tbl[p].rmask);
      chk_int("tbl_repeat_cnt", acc_rpt, tbl[p].rpt);
    end

    // Clean ku press held 12 cycles, then released.
    do_reset();
    for (int i = 0; i < 26; i++) begin
      cyc(1'b1, (i < 12) ? 5'b11101 : 5'b11111);
      chk("t2_press",   key_press,   (i == 10) ? 5'b00010 : 5'b0);
      chk("t2_release", key_release, (i == 22) ? 5'b00010 : 5'b0);
      chk("t2_level",   key_level,   (i >= 10 && i < 22) ? 5'b00010 : 5'b0);
    end

    // ke bounce on press (low 5, high 1, low 20) and on release (high 3, low 1, high).
    do_reset();
    for (int i = 0; i < 50; i++) begin
      kn = 5'b11111;
      kn[KEY_E] = !((i < 5) || (i >= 6 && i < 26) || (i == 29));
      cyc(1'b1, kn);
      chk("t3_press",   key_press,   (i == 16) ? 5'b00001 : 5'b0);
      chk("t3_release", key_release, (i == 40) ? 5'b00001 : 5'b0);
    end

    // kd held 60 cycles repeats at +20, +26 ...; kl held 60 never repeats.
    do_reset();
    for (int i = 0; i < 75; i++) begin
      kn = 5'b11111;
      kn[KEY_D] = (i >= 60);
      cyc(1'b1, kn);
      chk("t4_rpt_kd", key_repeat,
          (i >= 30 && i <= 60 && ((i - 30) % 6) == 0) ? 5'b00100 : 5'b0);
    end
    do_reset();
    acc_press = '0;
    for (int i = 0; i < 75; i++) begin
      kn = 5'b11111;
      kn[KEY_L] = (i >= 60);
      cyc(1'b1, kn);
      chk("t4_rpt_kl", key_repeat, 5'b0);
    end
    chk("t4_kl_pressed", acc_press, 5'b01000);

    // ke and kr together; any_pressed tracks until both released.
    do_reset();
    for (int i = 0; i < 42; i++) begin
      kn = 5'b11111;
      kn[KEY_E] = (i >= 20);
      kn[KEY_R] = (i >= 25);
      cyc(1'b1, kn);
      chk("t5_press", key_press, (i == 10) ? 5'b10001 : 5'b0);
      chk("t5_release", key_release,
          (i == 30) ? 5'b00001 : (i == 35) ? 5'b10000 : 5'b0);
      chk("t5_any", {4'b0, any_pressed}, (i >= 11 && i <= 35) ? 5'b1 : 5'b0);
    end

    // Reset while ku held: level drops, no release, fresh press 10 cycles later.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      cyc((i != 15), 5'b11101);
      chk("t6_press",   key_press,   (i == 10 || i == 26) ? 5'b00010 : 5'b0);
      chk("t6_release", key_release, 5'b0);
      if (i == 15) chk("t6_level_rst", key_level, 5'b0);
    end

    // Random bouncy keys with occasional reset, checked against the model.
    do_reset();
    kr = 5'b11111;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 5; k++)
        if ($urandom_range(0, 13) == 0) kr[k] = ~kr[k];
      r = ($urandom_range(0, 499) != 0);
      cyc(r, kr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
